systolic_feeder: RTL and testbench

- Upstream operand stage for the N x N PE systolic array.
- Buffers one N x N tile of matrix A and one N x N tile of matrix B, then clears the PE accumulators.
- Drives the west edge (a_in of column-0 PEs) and north edge (b_in of row-0 PEs) with diagonally skewed operands, zero padding, and a flush period.
- Reports done once every PE c_out holds the final C = A x B.

---
 rtl/systolic_pkg.sv | 29 ++
 rtl/systolic_operand_buf.sv | 61 ++++++
 rtl/systolic_feeder.sv | 110 +++++++++++
 tb/tb_systolic_feeder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic operand feeder and result drain.
// Phase enum plus cycle-count helpers derived from the array size.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DONE
    } state_t;

    function automatic int feed_cycles(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int flush_cycles(input int n);
        return n - 1;
    endfunction

    function automatic int addr_width(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/systolic_operand_buf.sv
// A and B tile register files with a diagonally skewed N-lane read.
// Lane i of A returns A[i][t-i]; lane j of B returns B[t-j][j]; else 0.
module systolic_operand_buf
    import systolic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int AW    = 2,
    parameter int CW    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic               sel,
    input  logic [AW-1:0]      addr,
    input  logic [WIDTH-1:0]   data,
    input  logic [CW-1:0]      t,
    output logic [N*WIDTH-1:0] a_lane,
    output logic [N*WIDTH-1:0] b_lane
);

    localparam logic [AW:0] DEPTH = (AW + 1)'(N * N);

    logic [WIDTH-1:0] mem_a [N*N];
    logic [WIDTH-1:0] mem_b [N*N];

    int            d;
    logic [AW-1:0] ia;
    logic [AW-1:0] ib;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N * N; k++) begin
                mem_a[k] <= '0;
                mem_b[k] <= '0;
            end
        end else if (we && ({1'b0, addr} < DEPTH)) begin
            if (sel) mem_b[addr] <= data;
            else     mem_a[addr] <= data;
        end
    end

    // Out-of-diagonal lanes read as zero so edge PEs accumulate +0.
    always_comb begin
        a_lane = '0;
        b_lane = '0;
        d      = 0;
        ia     = '0;
        ib     = '0;
        for (int i = 0; i < N; i++) begin
            d = int'(t) - i;
            if (d >= 0 && d < N) begin
                ia = AW'(i * N + d);
                ib = AW'(d * N + i);
                a_lane[i*WIDTH +: WIDTH] = mem_a[ia];
                b_lane[i*WIDTH +: WIDTH] = mem_b[ib];
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N PE array: buffers A/B tiles, clears the
// array, streams skewed edges, flushes, then pulses done.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int AW    = addr_width(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               wr_sel,
    input  logic [AW-1:0]      wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               acc_clr,
    output logic [N*WIDTH-1:0] a_edge,
    output logic [N*WIDTH-1:0] b_edge
);

    localparam int          CW         = cnt_width(N);
    localparam logic [CW-1:0] FEED_LAST  = CW'(feed_cycles(N) - 1);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(flush_cycles(N) - 1);
    localparam bit          NO_FLUSH   = (flush_cycles(N) == 0);

    state_t             state;
    state_t             state_n;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_n;
    logic [N*WIDTH-1:0] a_lane;
    logic [N*WIDTH-1:0] b_lane;

    // Buffers are only writable while idle so a run sees a frozen tile.
    systolic_operand_buf #(
        .WIDTH (WIDTH),
        .N     (N),
        .AW    (AW),
        .CW    (CW)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .we     (wr_en && (state == IDLE)),
        .sel    (wr_sel),
        .addr   (wr_addr),
        .data   (wr_data),
        .t      (cnt_n),
        .a_lane (a_lane),
        .b_lane (b_lane)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (start) state_n = CLEAR;
            end
            CLEAR: begin
                cnt_n   = '0;
                state_n = FEED;
            end
            FEED: begin
                if (cnt == FEED_LAST) begin
                    cnt_n   = '0;
                    state_n = NO_FLUSH ? DONE : FLUSH;
                end
            end
            FLUSH: begin
                if (cnt == FLUSH_LAST) begin
                    cnt_n   = '0;
                    state_n = DONE;
                end
            end
            DONE: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            acc_clr <= 1'b0;
            a_edge  <= '0;
            b_edge  <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            busy    <= state_n inside {CLEAR, FEED, FLUSH};
            done    <= (state_n == DONE);
            acc_clr <= (state_n == CLEAR);
            a_edge  <= (state_n == FEED) ? a_lane : '0;
            b_edge  <= (state_n == FEED) ? b_lane : '0;
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder at N=4, N=2 and N=1 with a run-phase model
// and a behavioural PE array fed from the DUT edges.
module tb_systolic_feeder;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int n,
                       input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            if (bad <= 40)
                $display("FAIL N=%0d %s got=%0h want=%0h t=%0t",
                         n, nm, got, want, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gen
        localparam int NG  = (g == 0) ? 4 : ((g == 1) ? 2 : 1);
        localparam int AWG = (NG * NG > 1) ? $clog2(NG * NG) : 1;

        logic            rst     = 1'b1;
        logic            wr_en   = 1'b0;
        logic            wr_sel  = 1'b0;
        logic            start   = 1'b0;
        logic [AWG-1:0]  wr_addr = '0;
        logic [W-1:0]    wr_data = '0;
        logic            busy;
        logic            done;
        logic            acc_clr;
        logic [NG*W-1:0] a_edge;
        logic [NG*W-1:0] b_edge;

        systolic_feeder #(.WIDTH(W), .N(NG)) dut (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en),
            .wr_sel  (wr_sel),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .start   (start),
            .busy    (busy),
            .done    (done),
            .acc_clr (acc_clr),
            .a_edge  (a_edge),
            .b_edge  (b_edge)
        );

        // Model: k is the cycle number within a run (0 = idle).
        int              k = 0;
        int              mA[16];
        int              mB[16];
        logic            e_busy, e_done, e_clr;
        logic [NG*W-1:0] e_a, e_b;

        int pa[4][4], pb[4][4], pc[4][4];

        int   cur_a[7][4], cur_b[7][4], cur_c[4][4];
        logic cur_clr;
        int   cap_a[7][4], cap_b[7][4], cap_c[4][4];
        logic cap_clr;
        int   cap_lat, cap_lat2, cap_bp, cap_sc, cap_nz;
        logic fin = 1'b0;

        always @(posedge clk) begin : model
            int d;
            if (rst) begin
                k = 0;
                for (int i = 0; i < 16; i++) begin
                    mA[i] = 0;
                    mB[i] = 0;
                end
            end else begin
                if (k == 0 && wr_en && int'(wr_addr) < NG * NG) begin
                    if (wr_sel) mB[int'(wr_addr)] = int'(wr_data);
                    else        mA[int'(wr_addr)] = int'(wr_data);
                end
                if (k == 0)           k = start ? 1 : 0;
                else if (k == 3 * NG) k = 0;
                else                  k = k + 1;
            end
            e_busy = (k >= 1 && k <= 3 * NG - 1);
            e_clr  = (k == 1);
            e_done = (k == 3 * NG);
            e_a    = '0;
            e_b    = '0;
            if (k >= 2 && k <= 2 * NG) begin
                for (int i = 0; i < NG; i++) begin
                    d = k - 2 - i;
                    if (d >= 0 && d < NG) begin
                        e_a[i*W +: W] = W'(mA[i * NG + d]);
                        e_b[i*W +: W] = W'(mB[d * NG + i]);
                    end
                end
            end
        end

        // Behavioural PE grid driven by the DUT edges; acc_clr is its reset.
        always @(posedge clk) begin : pe
            int na[4][4], nb[4][4];
            if (acc_clr) begin
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++) begin
                        pa[i][j] = 0;
                        pb[i][j] = 0;
                        pc[i][j] = 0;
                    end
            end else begin
                for (int i = 0; i < NG; i++)
                    for (int j = 0; j < NG; j++) begin
                        if (j == 0) na[i][j] = int'(a_edge[i*W +: W]);
                        else        na[i][j] = pa[i][j-1];
                        if (i == 0) nb[i][j] = int'(b_edge[j*W +: W]);
                        else        nb[i][j] = pb[i-1][j];
                    end
                for (int i = 0; i < NG; i++)
                    for (int j = 0; j < NG; j++) begin
                        pc[i][j] = pc[i][j] + na[i][j] * nb[i][j];
                        pa[i][j] = na[i][j];
                        pb[i][j] = nb[i][j];
                    end
            end
        end

        always @(negedge clk) begin : cmp
            int s;
            chk("busy", NG, busy, e_busy);
            chk("done", NG, done, e_done);
            chk("acc_clr", NG, acc_clr, e_clr);
            chk("a_edge", NG, a_edge, e_a);
            chk("b_edge", NG, b_edge, e_b);
            if (e_done) begin
                for (int i = 0; i < NG; i++)
                    for (int j = 0; j < NG; j++) begin
                        s = 0;
                        for (int m = 0; m < NG; m++)
                            s = s + mA[i * NG + m] * mB[m * NG + j];
                        chk("c_out", NG, pc[i][j], s);
                    end
            end
        end

        task automatic wr(input logic s, input int a, input int v);
            wr_en   = 1'b1;
            wr_sel  = s;
            wr_addr = AWG'(a);
            wr_data = W'(v);
            @(negedge clk);
            wr_en = 1'b0;
        endtask

        task automatic run_capture(input bit inj, output int lat);
            int inj_at;
            inj_at = (NG == 1) ? 1 : 2;
            for (int t = 0; t < 7; t++)
                for (int i = 0; i < 4; i++) begin
                    cur_a[t][i] = 0;
                    cur_b[t][i] = 0;
                end
            start = 1'b1;
            @(negedge clk);
            start   = 1'b0;
            wr_en   = 1'b0;
            cur_clr = acc_clr;
            lat     = 0;
            while (!done && lat < 100) begin
                @(negedge clk);
                lat++;
                start = 1'b0;
                wr_en = 1'b0;
                if (lat <= 2 * NG - 1)
                    for (int i = 0; i < NG; i++) begin
                        cur_a[lat-1][i] = int'(a_edge[i*W +: W]);
                        cur_b[lat-1][i] = int'(b_edge[i*W +: W]);
                    end
                if (inj && lat == inj_at) begin
                    start   = 1'b1;
                    wr_en   = 1'b1;
                    wr_sel  = 1'b0;
                    wr_addr = '0;
                    wr_data = 8'd99;
                end
            end
            start = 1'b0;
            wr_en = 1'b0;
            chk("done_seen", NG, done, 1);
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    cur_c[i][j] = pc[i][j];
        endtask

        initial begin : stim
            int lat;
            int va, vb;
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            for (int idx = 0; idx < NG * NG; idx++) begin
                if (NG == 1)      begin va = 3; vb = 7; end
                else if (NG == 2) begin va = idx + 1; vb = idx + 5; end
                else begin
                    va = int'($urandom_range(255));
                    vb = int'($urandom_range(255));
                end
                wr(1'b0, idx, va);
                wr(1'b1, idx, vb);
            end
            @(negedge clk);
            run_capture(1'b0, lat);
            cap_a   = cur_a;
            cap_b   = cur_b;
            cap_c   = cur_c;
            cap_clr = cur_clr;
            cap_lat = lat;
            repeat (2) @(negedge clk);
            run_capture(1'b1, lat);
            @(negedge clk);
            run_capture(1'b0, lat);
            cap_bp   = cur_a[0][0];
            cap_lat2 = lat;
            @(negedge clk);
            wr_en   = 1'b1;
            wr_sel  = 1'b0;
            wr_addr = '0;
            wr_data = 8'd9;
            run_capture(1'b0, lat);
            cap_sc = cur_a[0][0];
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            run_capture(1'b0, lat);
            cap_nz = 0;
            for (int t = 0; t < 7; t++)
                for (int i = 0; i < 4; i++)
                    if (cur_a[t][i] != 0 || cur_b[t][i] != 0) cap_nz++;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    if (cur_c[i][j] != 0) cap_nz++;
            repeat (400) begin
                rst     = ($urandom_range(49) == 0);
                wr_en   = $urandom_range(1) == 1;
                wr_sel  = $urandom_range(1) == 1;
                wr_addr = AWG'($urandom);
                wr_data = W'($urandom);
                start   = ($urandom_range(4) == 0);
                @(negedge clk);
            end
            rst   = 1'b0;
            wr_en = 1'b0;
            start = 1'b0;
            repeat (4 * NG + 4) @(negedge clk);
            fin = 1'b1;
        end
    end

    initial begin : main
        int cyc;
        int ea[3][2];
        int eb[3][2];
        ea = '{'{1, 0}, '{2, 3}, '{0, 4}};
        eb = '{'{5, 0}, '{7, 6}, '{0, 8}};
        cyc = 0;
        while (!(gen[0].fin && gen[1].fin && gen[2].fin) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk("all_fin", 0, gen[0].fin && gen[1].fin && gen[2].fin, 1);

        chk("clr", 2, gen[1].cap_clr, 1);
        for (int t = 0; t < 3; t++)
            for (int i = 0; i < 2; i++) begin
                chk("skew_a", 2, gen[1].cap_a[t][i], ea[t][i]);
                chk("skew_b", 2, gen[1].cap_b[t][i], eb[t][i]);
            end
        chk("c00", 2, gen[1].cap_c[0][0], 19);
        chk("c01", 2, gen[1].cap_c[0][1], 22);
        chk("c10", 2, gen[1].cap_c[1][0], 43);
        chk("c11", 2, gen[1].cap_c[1][1], 50);
        chk("latency", 2, gen[1].cap_lat, 5);
        chk("b2b_latency", 2, gen[1].cap_lat2, 5);
        chk("busy_prot_a0", 2, gen[1].cap_bp, 1);
        chk("same_cycle_a0", 2, gen[1].cap_sc, 9);
        chk("after_rst_zero", 2, gen[1].cap_nz, 0);

        chk("a0", 1, gen[2].cap_a[0][0], 3);
        chk("b0", 1, gen[2].cap_b[0][0], 7);
        chk("c00", 1, gen[2].cap_c[0][0], 21);
        chk("latency", 1, gen[2].cap_lat, 2);
        chk("busy_prot_a0", 1, gen[2].cap_bp, 3);
        chk("same_cycle_a0", 1, gen[2].cap_sc, 9);

        chk("clr", 4, gen[0].cap_clr, 1);
        chk("latency", 4, gen[0].cap_lat, 11);
        chk("b2b_latency", 4, gen[0].cap_lat2, 11);
        chk("same_cycle_a0", 4, gen[0].cap_sc, 9);
        chk("after_rst_zero", 4, gen[0].cap_nz, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
